dmem_dma: RTL and testbench
===========================

// Module: dmem_dma
// PURPOSE
//  Block copy/fill engine that masters the data-memory port (the initiator side of dmem's
//  we/addr/wdata/rdata interface). Software- or testbench-triggered; moves len words from src
//  to dst (COPY) or writes fill_value to len words at dst (FILL). Sits beside the datapath and
//  owns the dmem port while busy; top level muxes the port back to the core when idle.
// PARAMETERS
//  n  16  data/address word width (bits)
//  r  8   implemented memory address bits; memory depth = 2**r words
// PORTS
//  clk         in   1  system clock; all state updates on posedge
//  reset       in   1  asynchronous, active-high reset
//  start       in   1  request; sampled only in IDLE
//  mode        in   1  0 = COPY, 1 = FILL; sampled with start
//  src         in   n  COPY source word address; sampled with start
//  dst         in   n  destination word address; sampled with start
//  len         in   n  word count; sampled with start; 0 is legal
//  fill_value  in   n  FILL data; sampled with start
//  abort       in   1  cancel transfer in progress
//  busy        out  1  high in READ/WRITE states
//  done        out  1  one-cycle pulse on normal completion
//  mem_we      out  1  memory write_enable
//  mem_addr    out  n  memory addr; bits [n-1:r] always 0
//  mem_wdata   out  n  memory writedata
//  mem_rdata   in   n  memory readdata (combinational, same-cycle)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0;
//   all internal counters/regs cleared. Reset mid-transfer aborts at once; no done pulse.
//  Memory contract: read data valid in the same cycle addr is driven; write commits at posedge
//   where mem_we=1. Outputs are registered (state-decoded from registered state/regs).
//  States: IDLE, READ, WRITE, DONE.
//  IDLE: start=1 at posedge latches src,dst,len,mode,fill_value; len=0 -> DONE;
//   else COPY -> READ, FILL -> WRITE. start=0 -> stay.
//  READ (COPY only): mem_we=0, mem_addr=src_ptr; posedge captures mem_rdata into data_reg -> WRITE.
//  WRITE: mem_we=1, mem_addr=dst_ptr, mem_wdata=data_reg (COPY) or fill_value (FILL).
//   At posedge: ptrs increment, remaining decrements; remaining reaches 0 -> DONE,
//   else COPY -> READ, FILL -> WRITE.
//  DONE: done=1, busy=0, mem_we=0 for exactly one cycle -> IDLE.
//  Throughput: COPY = 2 cycles/word (busy 2*len cycles); FILL = 1 cycle/word (busy len cycles).
//   done asserts the cycle after the last write cycle; len=0 gives done one cycle after start.
//  Pointers: src_ptr/dst_ptr are r bits, increment modulo 2**r (0xFF -> 0x00 at r=8);
//   upper input bits [n-1:r] ignored. len counts full n bits (len > 2**r wraps and rewrites).
//  Overlap: ascending forward copy, no hazard detection; dst in (src, src+len) replicates data.
//  start while busy or in DONE: ignored (not queued).
//  abort: sampled in READ/WRITE; at that posedge -> IDLE, no done; a write cycle coinciding with
//   abort still commits (mem_we already driven). abort in IDLE/DONE: no effect; DONE completes.
//  start and abort both high in IDLE: start wins (abort ignored in IDLE).
// STRUCTURE
//  dmem_dma_pkg: state_t enum {IDLE,READ,WRITE,DONE}; MODE_COPY=1'b0, MODE_FILL=1'b1.
//  Sub-module dmem_dma_agen: r-bit loadable pointer with inc, used twice (src, dst).
//  Top: FSM, remaining counter (n bits), data_reg, output registers.
// TESTING (bench pairs dmem_dma with dmem n=16,r=8)
//  COPY src=0x10,dst=0x40,len=4, RAM[0x10..13]=A1,B2,C3,D4 -> RAM[0x40..43] match; busy 8 cyc; 1 done.
//  FILL dst=0x20,len=3,fill_value=0xBEEF -> RAM[0x20..22]=0xBEEF, RAM[0x23] unchanged; busy 3 cyc.
//  FILL dst=0xFE,len=4,fill_value=0x1234 -> RAM[0xFE,0xFF,0x00,0x01] written; mem_addr[15:8]=0.
//  len=0 start -> no mem_we ever, done pulses one cycle after start, busy stays 0.
//  COPY len=8, abort at 3rd WRITE cycle -> 3 words copied, rest unchanged, no done; start while
//   busy ignored (a 2nd start mid-transfer changes nothing).
//  Assert reset mid-COPY -> same cycle mem_we=0,busy=0; after release, new FILL completes normally.

Source files
------------

// File: rtl/dmem_dma_pkg.sv
// Shared types for the dmem block copy/fill engine.
// FSM state encoding and transfer mode constants.
package dmem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dmem_dma_agen.sv
// Loadable r-bit word pointer with increment.
// Wraps modulo 2**r so transfers roll over the top of memory.
module dmem_dma_agen
    import dmem_dma_pkg::*;
#(
    parameter int r = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [r-1:0] init,
    input  logic         inc,
    output logic [r-1:0] ptr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= init;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_dma.sv
// Block copy/fill engine mastering the data-memory port.
// COPY alternates READ/WRITE per word; FILL streams WRITE cycles.
module dmem_dma
    import dmem_dma_pkg::*;
#(
    parameter int n = 16,
    parameter int r = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [n-1:0] src,
    input  logic [n-1:0] dst,
    input  logic [n-1:0] len,
    input  logic [n-1:0] fill_value,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata
);

    state_t       state;
    state_t       state_nxt;
    logic [n-1:0] remaining;
    logic [n-1:0] data_reg;
    logic [n-1:0] fill_reg;
    logic         mode_reg;
    logic [r-1:0] src_ptr;
    logic [r-1:0] dst_ptr;
    logic         accept;
    logic         advance;
    logic         unused_hi;

    assign unused_hi = ^{src[n-1:r], dst[n-1:r]};

    assign accept  = (state == IDLE) && start;
    assign advance = (state == WRITE) && !abort;

    dmem_dma_agen #(.r(r)) u_src (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .init  (src[r-1:0]),
        .inc   (advance),
        .ptr   (src_ptr)
    );

    dmem_dma_agen #(.r(r)) u_dst (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .init  (dst[r-1:0]),
        .inc   (advance),
        .ptr   (dst_ptr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nxt = DONE;
                    end else if (mode == MODE_FILL) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                state_nxt = abort ? IDLE : WRITE;
            end
            WRITE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (remaining == {{(n-1){1'b0}}, 1'b1}) begin
                    state_nxt = DONE;
                end else if (mode_reg == MODE_FILL) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = READ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            data_reg  <= '0;
            fill_reg  <= '0;
            mode_reg  <= MODE_COPY;
        end else begin
            if (accept) begin
                remaining <= len;
                fill_reg  <= fill_value;
                mode_reg  <= mode;
            end else if (advance) begin
                remaining <= remaining - 1'b1;
            end
            if (state == READ && !abort) begin
                data_reg <= mem_rdata;
            end
        end
    end

    // Port outputs decode purely from registered state and pointers.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            READ: begin
                busy     = 1'b1;
                mem_addr = {{(n-r){1'b0}}, src_ptr};
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {{(n-r){1'b0}}, dst_ptr};
                mem_wdata = (mode_reg == MODE_FILL) ? fill_reg : data_reg;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_dma.sv
// Directed bench for dmem_dma paired with a 256x16 data memory.
// Expected values are hand-computed per transfer.
module tb_dmem_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] dst = '0;
    logic [15:0] len = '0;
    logic [15:0] fill_value = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;
    logic [15:0] ram [256];

    int total = 0;
    int bad = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int hi_err = 0;
    int b0, d0, w0, wc;

    always #5 clk = ~clk;

    dmem_dma #(.n(16), .r(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .fill_value (fill_value),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end else if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end
    end

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (mem_we) we_cnt++;
        if (mem_addr[15:8] != 8'h00) hi_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic snap();
        b0 = busy_cnt;
        d0 = done_cnt;
        w0 = we_cnt;
    endtask

    task automatic go(input logic m, input logic [15:0] s,
                      input logic [15:0] d, input logic [15:0] l,
                      input logic [15:0] f);
        mode = m;
        src = s;
        dst = d;
        len = l;
        fill_value = f;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            if (!busy && !done) break;
            tick();
        end
        chk(tag, (i < 200) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 16'h0000);
        tick();
        reset = 1'b0;
        tick();

        poke(8'h10, 16'h00A1);
        poke(8'h11, 16'h00B2);
        poke(8'h12, 16'h00C3);
        poke(8'h13, 16'h00D4);
        poke(8'h44, 16'h4444);
        poke(8'h23, 16'h5555);
        poke(8'h02, 16'h0202);
        poke(8'h60, 16'h6060);
        for (int k = 0; k < 8; k++) begin
            poke(8'h80 + 8'(k), 16'h0100 + 16'(k));
            poke(8'h90 + 8'(k), 16'h9393);
        end

        // COPY 4 words 0x10 -> 0x40
        snap();
        go(1'b0, 16'h0010, 16'h0040, 16'd4, 16'h0);
        wait_idle("copy_to");
        chk("copy_w0", ram[8'h40], 16'h00A1);
        chk("copy_w1", ram[8'h41], 16'h00B2);
        chk("copy_w2", ram[8'h42], 16'h00C3);
        chk("copy_w3", ram[8'h43], 16'h00D4);
        chk("copy_keep", ram[8'h44], 16'h4444);
        chk("copy_busy", busy_cnt - b0, 8);
        chk("copy_done", done_cnt - d0, 1);
        chk("copy_we", we_cnt - w0, 4);

        // FILL 3 words at 0x20
        snap();
        go(1'b1, 16'h0, 16'h0020, 16'd3, 16'hBEEF);
        wait_idle("fill_to");
        chk("fill_w0", ram[8'h20], 16'hBEEF);
        chk("fill_w1", ram[8'h21], 16'hBEEF);
        chk("fill_w2", ram[8'h22], 16'hBEEF);
        chk("fill_keep", ram[8'h23], 16'h5555);
        chk("fill_busy", busy_cnt - b0, 3);
        chk("fill_done", done_cnt - d0, 1);

        // FILL across the top of memory, upper dst bits ignored
        snap();
        go(1'b1, 16'h0, 16'hABFE, 16'd4, 16'h1234);
        wait_idle("wrap_to");
        chk("wrap_fe", ram[8'hFE], 16'h1234);
        chk("wrap_ff", ram[8'hFF], 16'h1234);
        chk("wrap_00", ram[8'h00], 16'h1234);
        chk("wrap_01", ram[8'h01], 16'h1234);
        chk("wrap_keep", ram[8'h02], 16'h0202);
        chk("wrap_hi", hi_err, 0);
        chk("wrap_busy", busy_cnt - b0, 4);

        // len = 0
        snap();
        go(1'b0, 16'h0010, 16'h0050, 16'd0, 16'h0);
        chk("len0_done", done, 1'b1);
        chk("len0_busy", busy, 1'b0);
        tick();
        chk("len0_pulse", done, 1'b0);
        chk("len0_we", we_cnt - w0, 0);
        chk("len0_bcnt", busy_cnt - b0, 0);
        chk("len0_dcnt", done_cnt - d0, 1);

        // COPY 8 words, stray start mid-way, abort on 3rd write
        snap();
        go(1'b0, 16'h0080, 16'h0090, 16'd8, 16'h0);
        mode = 1'b1;
        dst = 16'h0090;
        fill_value = 16'hDEAD;
        wc = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_we) wc++;
            if (wc == 3) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                break;
            end
            start = (i == 1);
            tick();
        end
        start = 1'b0;
        chk("abt_seen", wc, 3);
        chk("abt_busy", busy, 1'b0);
        tick();
        tick();
        chk("abt_idle", busy, 1'b0);
        chk("abt_done", done_cnt - d0, 0);
        chk("abt_we", we_cnt - w0, 3);
        for (int k = 0; k < 3; k++) begin
            chk("abt_copied", ram[8'h90 + 8'(k)], 16'h0100 + 16'(k));
        end
        for (int k = 3; k < 8; k++) begin
            chk("abt_keep", ram[8'h90 + 8'(k)], 16'h9393);
        end

        // reset mid-COPY, then a clean FILL
        go(1'b0, 16'h0010, 16'h0060, 16'd4, 16'h0);
        tick();
        chk("pre_rst_we", mem_we, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_addr", mem_addr, 16'h0000);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_nowrite", ram[8'h60], 16'h6060);
        snap();
        go(1'b1, 16'h0, 16'h0070, 16'd2, 16'h7777);
        wait_idle("post_to");
        chk("post_w0", ram[8'h70], 16'h7777);
        chk("post_w1", ram[8'h71], 16'h7777);
        chk("post_done", done_cnt - d0, 1);
        chk("post_busy", busy_cnt - b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
